uart_tx_duas_palavras: RTL and testbench

Two-byte UART transmitter carrying FPGA-to-PC responses: 16-bit result → two back-to-back 8N1 frames on the serial TX line. Counterpart of the two-byte command path received by `uart_rx`. Sits between the response-processing logic (DHT11 result formatting) and the physical TX pin of the FPGA top level.

---
 rtl/uart_tx_duas_palavras.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_duas_palavras.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_duas_palavras.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_duas_palavras
// Purpose  : Sends a 16-bit response as two back-to-back 8N1 UART frames,
//            high byte first, each byte LSB first. There is no idle gap
//            between the two frames.
// Ports    : clock               - system clock, rising edge
//            reset               - asynchronous, active-low reset
//            iniciarTransmissao  - start request (taken only when free)
//            dadosParaEnviar     - 16-bit payload, latched at start
//            bitSerialAtualTX    - serial TX line, idle high
//            indicaTransmissao   - busy flag
//            bitsEstaoEnviados   - one-cycle done pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_duas_palavras #(
    parameter int CLOCKS_POR_BIT = 5208
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciarTransmissao,
    input  logic [15:0] dadosParaEnviar,
    output logic        bitSerialAtualTX,
    output logic        indicaTransmissao,
    output logic        bitsEstaoEnviados
);

    localparam int CW = $clog2(CLOCKS_POR_BIT);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(CLOCKS_POR_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        BIT_INICIO = 3'd1,
        BITS_DADOS = 3'd2,
        BIT_PARADA = 3'd3,
        LIMPEZA    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic           byte_q, byte_d;
    logic [15:0]    data_q, data_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [7:0]     cur_byte;
    logic [2:0]     bit_nxt;
    logic           last_cycle;

    assign cur_byte   = byte_q ? data_q[7:0] : data_q[15:8];
    assign bit_nxt    = bit_q + 3'd1;
    assign last_cycle = (cnt_q == LAST_CYCLE);

    // Outputs are computed one cycle ahead from the next state so that all
    // of them come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            // The edge that leaves LIMPEZA is already the first idle edge,
            // so a start held high there is taken; this gives the 20C+1
            // back-to-back spacing.
            OCIOSO, LIMPEZA: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (state_q == LIMPEZA) begin
                    state_d = OCIOSO;
                end
                if (iniciarTransmissao) begin
                    data_d  = dadosParaEnviar;
                    byte_d  = 1'b0;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = BIT_INICIO;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            BIT_INICIO: begin
                if (last_cycle) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = BITS_DADOS;
                    tx_d    = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            BITS_DADOS: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    bit_d = bit_nxt;  // wraps 7 -> 0 on the last data bit
                    if (bit_q == 3'd7) begin
                        state_d = BIT_PARADA;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = cur_byte[bit_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            BIT_PARADA: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = BIT_INICIO;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = LIMPEZA;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = OCIOSO;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= OCIOSO;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            data_q  <= 16'h0000;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bitSerialAtualTX  = tx_q;
    assign indicaTransmissao = busy_q;
    assign bitsEstaoEnviados = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_duas_palavras.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_duas_palavras
// Purpose  : Self-checking bench. Two instances (CLOCKS_POR_BIT = 4 and 2)
//            share clock and reset. Each frame request pushes the expected
//            per-cycle {line, busy, done} values into a queue, which is
//            popped and compared once per cycle, #1 after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_duas_palavras;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        st4 = 1'b0, st2 = 1'b0;
    logic [15:0] d4 = 16'h0, d2 = 16'h0;
    logic        tx4, busy4, done4;
    logic        tx2, busy2, done2;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    always #5 clock = ~clock;

    uart_tx_duas_palavras #(.CLOCKS_POR_BIT(4)) dut4 (
        .clock(clock), .reset(reset),
        .iniciarTransmissao(st4), .dadosParaEnviar(d4),
        .bitSerialAtualTX(tx4), .indicaTransmissao(busy4),
        .bitsEstaoEnviados(done4)
    );

    uart_tx_duas_palavras #(.CLOCKS_POR_BIT(2)) dut2 (
        .clock(clock), .reset(reset),
        .iniciarTransmissao(st2), .dadosParaEnviar(d2),
        .bitSerialAtualTX(tx2), .indicaTransmissao(busy2),
        .bitsEstaoEnviados(done2)
    );

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got{line,busy,done}=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] obs(input int sel);
        return (sel == 4) ? {tx4, busy4, done4} : {tx2, busy2, done2};
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [15:0] d);
        if (sel == 4) begin st4 = st; d4 = d; end
        else          begin st2 = st; d2 = d; end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 4) st4 = st; else st2 = st;
    endtask

    // Protocol model: start, high byte LSB first, stop, start, low byte
    // LSB first, stop; each bit c cycles with busy set, then one done cycle.
    task automatic push_frame(input logic [15:0] d, input int c);
        logic [19:0] seq;
        seq[0]  = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i]  = d[8 + i];
        seq[9]  = 1'b1;
        seq[10] = 1'b0;
        for (int i = 0; i < 8; i++) seq[11 + i] = d[i];
        seq[19] = 1'b1;
        for (int k = 0; k < 20; k++)
            for (int j = 0; j < c; j++)
                exp_q.push_back({seq[k], 1'b1, 1'b0});
        exp_q.push_back(3'b101);
    endtask

    task automatic idle_check(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            check($sformatf("%s_c%0d", tag, i), obs(sel), 3'b100);
        end
    endtask

    // Called #1 after a rising edge. mode: 0 plain, 1 data change at E0+5,
    // 2 stray starts at E0+3 and E0+40, 3 async reset between edges at E0+30.
    task automatic run_frame(input int sel, input logic [15:0] d, input bit hold,
                             input int mode, input string tag);
        int cyc;
        logic [2:0] e;
        push_frame(d, sel);
        set_in(sel, 1'b1, d);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clock); #1;
            cyc++;
            if (!hold) set_start(sel, 1'b0);
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, cyc), obs(sel), e);
            if (mode == 1 && cyc == 5) set_in(sel, hold, 16'h1234);
            if (mode == 2 && (cyc == 3 || cyc == 40)) set_start(sel, 1'b1);
            if (mode == 2 && (cyc == 4 || cyc == 41)) set_start(sel, 1'b0);
            if (mode == 3 && cyc == 30) begin
                #2 reset = 1'b0;
                #1 check({tag, "_rst_async"}, obs(sel), 3'b100);
                exp_q.delete();
                for (int i = 0; i < 2; i++) begin
                    @(posedge clock); #1;
                    check($sformatf("%s_rst_hold%0d", tag, i), obs(sel), 3'b100);
                end
                #2 reset = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("reset_state_c4", obs(4), 3'b100);
        check("reset_state_c2", obs(2), 3'b100);
        reset = 1'b1;
        idle_check(4, 10, "idle4");
        idle_check(2, 3, "idle2");

        run_frame(4, 16'hA55A, 1'b0, 0, "a55a");
        idle_check(4, 3, "after_a55a");

        // Start held high: frame one must carry 0x00FF, frame two (latched at
        // E0+81 with no idle cycle) carries 0x1234.
        run_frame(4, 16'h00FF, 1'b1, 1, "held1");
        run_frame(4, 16'h1234, 1'b0, 0, "held2");
        idle_check(4, 3, "after_held");

        run_frame(4, 16'h3C96, 1'b0, 2, "ignore");
        idle_check(4, 5, "after_ignore");

        run_frame(4, 16'hBEEF, 1'b0, 3, "abort");
        run_frame(4, 16'h5AC3, 1'b0, 0, "post_rst");
        idle_check(4, 3, "after_post_rst");

        run_frame(2, 16'hFFFF, 1'b0, 0, "c2_ffff");
        idle_check(2, 3, "after_c2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
